vga_sync: RTL

VGA_SYNC -- requirements
Module: vga_sync

---
 rtl/vga_sync.sv | 103 ++++++++++
 1 files changed

// File: rtl/vga_sync.sv
// VGA timing generator: pixel-rate divider, h/v counters and registered
// sync/blanking/frame strobes that line up with x/y on the same clk.
module vga_sync #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int DIV       = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       p_tick,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       frame_start
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [4:0] DIV_MAX  = 5'(DIV - 1);
    localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [4:0] r_div_cnt;
    logic [9:0] r_h_cnt;
    logic [9:0] r_v_cnt;
    logic       r_hsync;
    logic       r_vsync;
    logic       r_video_on;
    logic       r_frame_start;

    logic       w_p_tick;
    logic       w_frame_wrap;
    logic [9:0] w_h_next;
    logic [9:0] w_v_next;

    // With DIV=1 the counter sits at 0 == DIV_MAX, so the tick is constant.
    assign w_p_tick = (r_div_cnt == DIV_MAX);

    always_comb begin
        w_h_next     = r_h_cnt;
        w_v_next     = r_v_cnt;
        w_frame_wrap = 1'b0;
        if (w_p_tick) begin
            if (r_h_cnt == H_MAX) begin
                w_h_next = '0;
                if (r_v_cnt == V_MAX) begin
                    w_v_next     = '0;
                    w_frame_wrap = 1'b1;
                end else begin
                    w_v_next = r_v_cnt + 10'd1;
                end
            end else begin
                w_h_next = r_h_cnt + 10'd1;
            end
        end
    end

    // Decoded outputs are loaded from next-state counts so they are glitch
    // free and change on the same edge as x/y.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt     <= '0;
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_video_on    <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_div_cnt     <= w_p_tick ? 5'd0 : r_div_cnt + 5'd1;
            r_h_cnt       <= w_h_next;
            r_v_cnt       <= w_v_next;
            r_hsync       <= !((w_h_next >= HS_START) && (w_h_next <= HS_END));
            r_vsync       <= !((w_v_next >= VS_START) && (w_v_next <= VS_END));
            r_video_on    <= (w_h_next < H_VIS) && (w_v_next < V_VIS);
            r_frame_start <= w_frame_wrap;
        end
    end

    assign p_tick      = w_p_tick;
    assign x           = r_h_cnt;
    assign y           = r_v_cnt;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign video_on    = r_video_on;
    assign frame_start = r_frame_start;

endmodule
